// File: rtl/alu_exec_unit_pkg.sv
// ---------------------------------------------------------------------------
// alu_exec_unit_pkg
// Shared definitions for the execute-stage ALU:
//   - 5-bit ALU control codes produced by the decode logic
//   - FSM state encoding for the top-level sequencer
//   - small helpers for signed add/sub overflow detection
// ---------------------------------------------------------------------------
package alu_exec_unit_pkg;

    localparam logic [4:0] ALU_PASS = 5'd0;
    localparam logic [4:0] ALU_ADD  = 5'd1;
    localparam logic [4:0] ALU_SUB  = 5'd2;
    localparam logic [4:0] ALU_AND  = 5'd3;
    localparam logic [4:0] ALU_OR   = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_NOR  = 5'd6;
    localparam logic [4:0] ALU_SLL  = 5'd7;
    localparam logic [4:0] ALU_SR   = 5'd8;
    localparam logic [4:0] ALU_SLT  = 5'd9;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Signed overflow on a+b: both operands share a sign that the sum lost.
    function automatic logic addOverflow(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic [31:0] sum);
        return (a[31] == b[31]) && (sum[31] != a[31]);
    endfunction

    // Signed overflow on a-b: operands differ in sign and the difference
    // took the sign of b instead of a.
    function automatic logic subOverflow(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic [31:0] diff);
        return (a[31] != b[31]) && (diff[31] != a[31]);
    endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// ---------------------------------------------------------------------------
// alu_shift_iter
// Iterative shifter: moves the work register by at most SHIFT_STEP bit
// positions per clock until the requested amount has been consumed.
// Ports:
//   clk, reset_n   clock / asynchronous active-low reset
//   i_start        load i_value / i_amount / direction and start shifting
//   i_left         1 = shift left, 0 = shift right
//   i_arith        right shifts only: 1 = sign-fill, 0 = zero-fill
//   i_value        value to be shifted
//   i_amount       shift amount (non-zero when i_start is used)
//   i_run          owner is in its shifting state; advance one step
//   o_done         this edge performs the final step
//   o_value        work register after the current step (valid with o_done)
// ---------------------------------------------------------------------------
module alu_shift_iter
    import alu_exec_unit_pkg::*;
#(
    parameter int SHIFT_STEP = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_start,
    input  logic        i_left,
    input  logic        i_arith,
    input  logic [31:0] i_value,
    input  logic [4:0]  i_amount,
    input  logic        i_run,
    output logic        o_done,
    output logic [31:0] o_value
);

    localparam logic [5:0] STEP = 6'(SHIFT_STEP);

    logic [31:0] r_work;
    logic [5:0]  r_rem;
    logic        r_left;
    logic        r_arith;

    logic [5:0]  w_k;
    logic [31:0] w_next;

    // Step size is the smaller of the per-cycle limit and what is left.
    // Sign-filling right shifts keep bit 31 unchanged, so repeated steps
    // keep replicating the original sign bit.
    always_comb begin
        w_k    = (r_rem < STEP) ? r_rem : STEP;
        w_next = r_work;
        if (r_left) begin
            w_next = r_work << w_k;
        end else if (r_arith) begin
            w_next = $signed(r_work) >>> w_k;
        end else begin
            w_next = r_work >> w_k;
        end
    end

    assign o_done  = i_run && (r_rem <= STEP);
    assign o_value = w_next;

    // Work register and remaining count: loaded on start, then consumed
    // one step per cycle while the owner keeps i_run asserted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_work  <= '0;
            r_rem   <= '0;
            r_left  <= 1'b0;
            r_arith <= 1'b0;
        end else if (i_start) begin
            r_work  <= i_value;
            r_rem   <= {1'b0, i_amount};
            r_left  <= i_left;
            r_arith <= i_arith;
        end else if (i_run) begin
            r_work  <= w_next;
            r_rem   <= r_rem - w_k;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
// Execute-stage ALU. Combinational ops and zero-amount shifts finish one
// edge after accept; non-zero shifts go through alu_shift_iter and stall
// the upstream handshake until the result is registered.
// Ports:
//   clk, reset_n           clock / asynchronous active-low reset
//   in_valid, in_ready     request handshake
//   alu_ctrl, sign         operation code and signedness
//   in_a, in_b             operands (in_a[4:0] = shift amount, in_b shifted)
//   out_valid, out_ready   result handshake
//   result, zero, overflow registered result and flags
// ---------------------------------------------------------------------------
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int SHIFT_STEP = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  alu_ctrl,
    input  logic        sign,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        zero,
    output logic        overflow
);

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_result;
    logic        r_zero;
    logic        r_overflow;
    logic        r_out_valid;

    logic        w_accept;
    logic        w_is_shift;
    logic        w_start;
    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic [31:0] w_alu_result;
    logic        w_alu_ovf;
    logic        w_shift_done;
    logic [31:0] w_shift_value;

    assign in_ready   = (r_state == IDLE) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_is_shift = (alu_ctrl == ALU_SLL) || (alu_ctrl == ALU_SR);
    assign w_start    = w_accept && w_is_shift && (in_a[4:0] != 5'd0);

    assign w_sum  = in_a + in_b;
    assign w_diff = in_a - in_b;

    // Single-cycle operations. Shift codes only reach the output from here
    // when the amount is zero, so passing in_b through is their result.
    always_comb begin
        w_alu_result = '0;
        w_alu_ovf    = 1'b0;
        case (alu_ctrl)
            ALU_PASS: w_alu_result = in_b;
            ALU_ADD: begin
                w_alu_result = w_sum;
                w_alu_ovf    = sign && addOverflow(in_a, in_b, w_sum);
            end
            ALU_SUB: begin
                w_alu_result = w_diff;
                w_alu_ovf    = sign && subOverflow(in_a, in_b, w_diff);
            end
            ALU_AND:  w_alu_result = in_a & in_b;
            ALU_OR:   w_alu_result = in_a | in_b;
            ALU_XOR:  w_alu_result = in_a ^ in_b;
            ALU_NOR:  w_alu_result = ~(in_a | in_b);
            ALU_SLL:  w_alu_result = in_b;
            ALU_SR:   w_alu_result = in_b;
            ALU_SLT: begin
                if (sign) begin
                    w_alu_result = {31'd0, $signed(in_a) < $signed(in_b)};
                end else begin
                    w_alu_result = {31'd0, in_a < in_b};
                end
            end
            default:  w_alu_result = '0;
        endcase
    end

    alu_shift_iter #(
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shift (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_start  (w_start),
        .i_left   (alu_ctrl == ALU_SLL),
        .i_arith  (sign),
        .i_value  (in_b),
        .i_amount (in_a[4:0]),
        .i_run    (r_state == SHIFT),
        .o_done   (w_shift_done),
        .o_value  (w_shift_value)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: leave IDLE only for a shift that actually moves bits,
    // and come back on the edge that performs the last step.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start)      w_state_next = SHIFT;
            SHIFT:   if (w_shift_done) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Output registers. A new result takes priority over draining, which
    // is what gives back-to-back results when out_ready and a new accept
    // coincide. Otherwise everything holds until downstream takes it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_accept && !w_start) begin
            r_result    <= w_alu_result;
            r_zero      <= (w_alu_result == 32'd0);
            r_overflow  <= w_alu_ovf;
            r_out_valid <= 1'b1;
        end else if ((r_state == SHIFT) && w_shift_done) begin
            r_result    <= w_shift_value;
            r_zero      <= (w_shift_value == 32'd0);
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign result    = r_result;
    assign zero      = r_zero;
    assign overflow  = r_overflow;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
// Directed, table-driven bench for alu_exec_unit (SHIFT_STEP = 4), plus
// hand-written sequences for reset, backpressure and reset during a shift.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  alu_ctrl;
    logic        sign;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        overflow;

    int total;
    int bad;

    typedef struct {
        logic [4:0]  ctrl;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expResult;
        logic        expZero;
        logic        expOvf;
        int          expLatency;
    } vec_t;

    vec_t vecs[$];

    alu_exec_unit #(
        .SHIFT_STEP (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .sign      (sign),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Present one vector, scramble operands after accept, wait for the
    // result with a cycle budget and check value, flags and latency.
    task automatic applyStimulus(input vec_t v, input int idx);
        int   cycles;
        logic sawReady;
        @(negedge clk);
        in_valid  = 1'b1;
        alu_ctrl  = v.ctrl;
        sign      = v.sgn;
        in_a      = v.a;
        in_b      = v.b;
        out_ready = 1'b1;
        #1;
        checkOutput($sformatf("v%0d.in_ready", idx), {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        sign     = ~v.sgn;
        cycles   = 1;
        sawReady = 1'b0;
        while (!out_valid && cycles < 50) begin
            if (in_ready) sawReady = 1'b1;
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput($sformatf("v%0d.out_valid", idx), {31'd0, out_valid}, 32'd1);
        checkOutput($sformatf("v%0d.latency", idx), 32'(cycles), 32'(v.expLatency));
        checkOutput($sformatf("v%0d.busy_ready", idx), {31'd0, sawReady}, 32'd0);
        checkOutput($sformatf("v%0d.result", idx), result, v.expResult);
        checkOutput($sformatf("v%0d.zero", idx), {31'd0, zero}, {31'd0, v.expZero});
        checkOutput($sformatf("v%0d.overflow", idx), {31'd0, overflow}, {31'd0, v.expOvf});
    endtask

    initial begin
        logic gotResult;
        logic held;

        total = 0;
        bad   = 0;

        // ctrl, sign, a, b, result, zero, ovf, latency
        vecs.push_back('{5'd0, 1'b0, 32'h00001234, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1});
        vecs.push_back('{5'd1, 1'b1, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1});
        vecs.push_back('{5'd1, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1});
        vecs.push_back('{5'd1, 1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1});
        vecs.push_back('{5'd2, 1'b1, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1});
        vecs.push_back('{5'd2, 1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1});
        vecs.push_back('{5'd2, 1'b0, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1});
        vecs.push_back('{5'd3, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1});
        vecs.push_back('{5'd4, 1'b0, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0, 1'b0, 1});
        vecs.push_back('{5'd5, 1'b0, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 1'b0, 1'b0, 1});
        vecs.push_back('{5'd6, 1'b0, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1});
        vecs.push_back('{5'd6, 1'b0, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1});
        vecs.push_back('{5'd9, 1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1});
        vecs.push_back('{5'd9, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1});
        vecs.push_back('{5'd31, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1});
        vecs.push_back('{5'd10, 1'b1, 32'h7FFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1});
        vecs.push_back('{5'd8, 1'b1, 32'd31, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 9});
        vecs.push_back('{5'd8, 1'b0, 32'd31, 32'h80000000, 32'h00000001, 1'b0, 1'b0, 9});
        vecs.push_back('{5'd7, 1'b0, 32'd0, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 1});
        vecs.push_back('{5'd7, 1'b0, 32'd4, 32'h12345678, 32'h23456780, 1'b0, 1'b0, 2});
        vecs.push_back('{5'd7, 1'b0, 32'd5, 32'h00000001, 32'h00000020, 1'b0, 1'b0, 3});
        vecs.push_back('{5'd7, 1'b0, 32'd31, 32'h00000003, 32'h80000000, 1'b0, 1'b0, 9});
        vecs.push_back('{5'd8, 1'b1, 32'd33, 32'hF0000000, 32'hF8000000, 1'b0, 1'b0, 2});
        vecs.push_back('{5'd8, 1'b1, 32'd8, 32'h7F000000, 32'h007F0000, 1'b0, 1'b0, 3});
        vecs.push_back('{5'd8, 1'b0, 32'd0, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 1});
        vecs.push_back('{5'd7, 1'b0, 32'hFFFFFFE0, 32'h00000005, 32'h00000005, 1'b0, 1'b0, 1});
        vecs.push_back('{5'd7, 1'b0, 32'd3, 32'h20000000, 32'h00000000, 1'b1, 1'b0, 2});

        // Reset held with a pending request: nothing may come out.
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        alu_ctrl  = 5'd1;
        sign      = 1'b1;
        in_a      = 32'h7FFFFFFF;
        in_b      = 32'h1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst.out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst.result", result, 32'd0);
        checkOutput("rst.zero", {31'd0, zero}, 32'd0);
        checkOutput("rst.overflow", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        reset_n  = 1'b1;
        #1;
        checkOutput("rst.in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst.out_valid_rel", {31'd0, out_valid}, 32'd0);

        foreach (vecs[i]) applyStimulus(vecs[i], i);

        // Drain and go idle.
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Backpressure: result must hold and the unit must refuse new work.
        alu_ctrl  = 5'd1;
        sign      = 1'b0;
        in_a      = 32'd3;
        in_b      = 32'd4;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        alu_ctrl = 5'd5;
        in_a     = 32'd1;
        in_b     = 32'd2;
        checkOutput("bp.first_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("bp.first_result", result, 32'd7);
        held = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (!out_valid || result !== 32'd7 || in_ready) held = 1'b0;
            @(posedge clk);
            #1;
        end
        checkOutput("bp.held", {31'd0, held}, 32'd1);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checkOutput("bp.ready_again", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("bp.b2b_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("bp.b2b_result", result, 32'd3);
        @(posedge clk);
        #1;
        checkOutput("bp.drained", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of a long shift: no result afterwards.
        @(negedge clk);
        alu_ctrl = 5'd8;
        sign     = 1'b1;
        in_a     = 32'd31;
        in_b     = 32'h80000000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("mid.busy", {31'd0, in_ready}, 32'd0);
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mid.out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("mid.in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        reset_n   = 1'b1;
        gotResult = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) gotResult = 1'b1;
        end
        checkOutput("mid.no_result", {31'd0, gotResult}, 32'd0);

        // The unit must be fully usable after the aborted shift.
        applyStimulus(vecs[16], 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execute-stage consumer of the 5-bit ALU control code and Sign bit that the decode logic produces from OpCode/Funct. It takes two 32-bit operands, performs the selected operation and returns a registered result with zero and overflow flags. Shifts run on an iterative barrel-lite shifter, so the unit stalls upstream through a valid/ready handshake.

Parameters:
SHIFT_STEP, 4, maximum bit positions shifted per cycle in the iterative shifter (power of two, 1..32)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  operation request valid
in_ready  output  1  unit can accept a request this cycle
alu_ctrl  input  5  operation code (see Behaviour)
sign  input  1  1 = signed semantics, 0 = unsigned
in_a  input  32  operand A; low 5 bits are the shift amount for shifts
in_b  input  32  operand B; the value shifted for shifts
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
result  output  32  operation result
zero  output  1  result == 0
overflow  output  1  signed add/sub overflow

Behaviour:
- Reset (async, reset_n=0): state IDLE, out_valid=0, result=0, zero=0, overflow=0, shift counter=0. Reset mid-shift aborts the operation and no result is produced.
- Codes: 0 result=in_b; 1 a+b; 2 a-b; 3 a&b; 4 a|b; 5 a^b; 6 ~(a|b); 7 b<<a[4:0]; 8 b>>a[4:0], arithmetic if sign=1, else logical; 9 set-less-than (signed compare if sign=1, unsigned if 0), result 32'd1 or 0; 10..31 result=0.
- Arithmetic is modulo 2^32.
- overflow=1 only for codes 1/2 with sign=1 and signed overflow; otherwise 0. zero is computed from the final 32-bit result.
- Handshake: transfer occurs when in_valid && in_ready at a clock edge. in_ready = (state==IDLE) && (!out_valid || out_ready).
- Output: result/zero/overflow/out_valid are held stable while out_valid=1 and out_ready=0. out_valid drops on the edge where out_ready=1, unless a new result is loaded on the same edge.
- FSM IDLE: on accept of a non-shift op, or a shift with amount 0, load the output registers and set out_valid=1 on that edge (latency 1). On accept of a shift with amount n>0, load the work register with in_b, set rem=n and the shift type, then go to SHIFT.
- FSM SHIFT: each edge shifts the work register by k=min(SHIFT_STEP, rem) and sets rem-=k. For sra the vacated bits take the original bit 31. When rem reaches 0, load result/flags, set out_valid=1 and return to IDLE. Shift latency = 1 + ceil(n/SHIFT_STEP) edges from accept. in_ready=0 throughout SHIFT.
- Simultaneous events: out_ready=1 together with a new accept in IDLE produces a back-to-back result, with out_valid staying 1. Inputs are sampled only at accept; changes during SHIFT are ignored.

Decomposition:
- Shared package: ALU_PASS=0, ALU_ADD=1, ALU_SUB=2, ALU_AND=3, ALU_OR=4, ALU_XOR=5, ALU_NOR=6, ALU_SLL=7, ALU_SR=8, ALU_SLT=9, and the FSM state encoding (IDLE, SHIFT).
- One sub-module, alu_shift_iter: holds the work register, remaining-count and direction/arith bits, with start/done signals.
- The combinational ops and the FSM stay in the top level.

Test Plan:
1. Reset: hold reset_n=0 with in_valid=1, then release -> out_valid=0, result=0, in_ready=1. Reset asserted mid-shift -> out_valid=0 immediately and no result afterwards.
2. ALU_ADD, sign=1, a=32'h7FFFFFFF, b=1 -> after 1 cycle result=32'h80000000, overflow=1, zero=0. Same with sign=0 -> overflow=0. ALU_SUB a=5, b=5 -> zero=1.
3. ALU_SLT, a=32'hFFFFFFFF, b=1: sign=1 -> result=1; sign=0 -> result=0.
4. ALU_SR, sign=1, b=32'h80000000, a=31, SHIFT_STEP=4 -> in_ready low for 8 cycles, result=32'hFFFFFFFF at 9 edges after accept. Same with sign=0 -> result=1. ALU_SLL a=0 -> latency 1, result=b.
5. Backpressure: out_ready=0 for 5 cycles after a result -> result held stable and in_ready=0. Then out_ready=1 with in_valid=1 -> next result on the following edge with no bubble.
6. Code 31, a=b=32'hFFFFFFFF -> result=0, zero=1, overflow=0.
